// File: rtl/gesture_power_ctrl.sv
// -----------------------------------------------------------------------------
// gesture_power_ctrl
//
// Gesture power switch. A left-then-right key gesture powers the unit on and a
// right-then-left gesture powers it off. The second key must arrive within
// gesture_sec seconds of the first. Pressing the first key again while the
// window is open restarts the window.
//
// Ports
//   clk_100Hz         in   1  system clock, 100 Hz
//   rst_n             in   1  asynchronous active-low reset
//   gesture_sec       in   6  gesture window in seconds (0..59), sampled at window load
//   left_press_once   in   1  one-cycle pulse, debounced left key
//   right_press_once  in   1  one-cycle pulse, debounced right key
//   power_on          out  1  registered power state
//   gesture_pending   out  1  high while waiting for the second key of a gesture
//   remain_sec        out  6  seconds left in the open window, rounded up; 0 when idle
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   OFF_IDLE    | powered off, waiting for a left key to open a window
//   ON_ARMING   | left seen while off, waiting for right to power on
//   ON_IDLE     | powered on, waiting for a right key to open a window
//   OFF_ARMING  | right seen while on, waiting for left to power off
// -----------------------------------------------------------------------------
module gesture_power_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic [5:0] gesture_sec,
  input  logic       left_press_once,
  input  logic       right_press_once,
  output logic       power_on,
  output logic       gesture_pending,
  output logic [5:0] remain_sec
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    OFF_IDLE   = 2'd0,
    ON_ARMING  = 2'd1,
    ON_IDLE    = 2'd2,
    OFF_ARMING = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [5:0]        window_q, window_d;
  logic              power_q, power_d;
  logic              pending_q, pending_d;

  logic left, right;
  logic tick_last, timeout, gs_valid;

  // A press of both keys in the same cycle counts as no press at all.
  assign left      = left_press_once & ~right_press_once;
  assign right     = right_press_once & ~left_press_once;
  assign tick_last = (tick_q == TICK_LAST);
  // window_q never legitimately reaches 0 while arming; treating 0 like 1
  // guarantees the register cannot wrap to 63.
  assign timeout   = tick_last && (window_q <= 6'd1);
  assign gs_valid  = (gesture_sec != 6'd0);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    window_d = window_q;

    case (state_q)
      OFF_IDLE: begin
        if (left && gs_valid) begin
          state_d  = ON_ARMING;
          window_d = gesture_sec;
          tick_d   = '0;
        end
      end

      ON_IDLE: begin
        if (right && gs_valid) begin
          state_d  = OFF_ARMING;
          window_d = gesture_sec;
          tick_d   = '0;
        end
      end

      ON_ARMING: begin
        // Completion is checked before timeout so a press in the last
        // cycle of the window still finishes the gesture.
        if (right) begin
          state_d  = ON_IDLE;
          window_d = '0;
          tick_d   = '0;
        end else if (left) begin
          if (gs_valid) begin
            window_d = gesture_sec;
            tick_d   = '0;
          end else begin
            state_d  = OFF_IDLE;
            window_d = '0;
            tick_d   = '0;
          end
        end else if (timeout) begin
          state_d  = OFF_IDLE;
          window_d = '0;
          tick_d   = '0;
        end else if (tick_last) begin
          tick_d   = '0;
          window_d = window_q - 6'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      OFF_ARMING: begin
        if (left) begin
          state_d  = OFF_IDLE;
          window_d = '0;
          tick_d   = '0;
        end else if (right) begin
          if (gs_valid) begin
            window_d = gesture_sec;
            tick_d   = '0;
          end else begin
            state_d  = ON_IDLE;
            window_d = '0;
            tick_d   = '0;
          end
        end else if (timeout) begin
          state_d  = ON_IDLE;
          window_d = '0;
          tick_d   = '0;
        end else if (tick_last) begin
          tick_d   = '0;
          window_d = window_q - 6'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: begin
        state_d  = OFF_IDLE;
        window_d = '0;
        tick_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they land on the same edge
    // as the state change.
    power_d   = (state_d == ON_IDLE) || (state_d == OFF_ARMING);
    pending_d = (state_d == ON_ARMING) || (state_d == OFF_ARMING);
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF_IDLE;
      tick_q    <= '0;
      window_q  <= '0;
      power_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      window_q  <= window_d;
      power_q   <= power_d;
      pending_q <= pending_d;
    end
  end

  // window_q is cleared on every move into an idle state, so it already
  // reads 0 whenever no window is open.
  assign power_on        = power_q;
  assign gesture_pending = pending_q;
  assign remain_sec      = window_q;

endmodule

// File: doc/gesture_power_ctrl.md
Name: gesture_power_ctrl

Overview:
- Gesture power switch. Consumes the user-set gesture window `gesture_sec` and single-cycle left/right button pulses (`*_press_once`).
- Powers the unit on with a left-then-right gesture, and off with a right-then-left gesture.
- The second press must arrive within `gesture_sec` seconds of the first.
- Feeds `power_on` to the mode controller and `remain_sec` to the display mux.

Parameters:
- TICKS_PER_SEC, 100, clk_100Hz cycles per second of gesture window.

Ports:
- clk_100Hz  input  1  system clock, 100 Hz.
- rst_n  input  1  reset, asynchronous, active-low.
- gesture_sec  input  6  gesture window in seconds, 0..59, from the time-setting stage.
- left_press_once  input  1  one-cycle pulse, debounced left key.
- right_press_once  input  1  one-cycle pulse, debounced right key.
- power_on  output  1  registered power state.
- gesture_pending  output  1  high while waiting for the second key of a gesture.
- remain_sec  output  6  seconds left in the open window, rounded up; 0 when no window is open.

Behaviour:
- Reset (async, rst_n low):
  - state=OFF_IDLE.
  - power_on=0, gesture_pending=0, remain_sec=0.
  - Tick counter = 0, window register = 0.
- States: OFF_IDLE, ON_ARMING, ON_IDLE, OFF_ARMING. One registered state register; all outputs registered.
- Simultaneous left & right pulses in the same cycle are ignored in every state. There is no transition and no window reload.
- OFF_IDLE:
  - left with gesture_sec!=0 → ON_ARMING. Load window=gesture_sec, tick=0.
  - left with gesture_sec==0 → ignored.
  - right → ignored.
- ON_ARMING:
  - right → ON_IDLE. power_on=1 on the next edge (one cycle after the pulse).
  - left → window restart: reload window=gesture_sec, tick=0. If gesture_sec is now 0 → OFF_IDLE.
  - timeout → OFF_IDLE, power_on stays 0.
- ON_IDLE:
  - right with gesture_sec!=0 → OFF_ARMING. Load window=gesture_sec, tick=0.
  - right with gesture_sec==0 → ignored.
  - left → ignored.
- OFF_ARMING:
  - left → OFF_IDLE, power_on=0 next edge.
  - right → window restart, same rule as ON_ARMING.
  - timeout → ON_IDLE, power_on stays 1.
- Window timing:
  - In ARMING states, tick increments each cycle, 0..TICKS_PER_SEC-1.
  - At tick==TICKS_PER_SEC-1: tick wraps to 0 and window decrements.
  - Timeout is the cycle where tick==TICKS_PER_SEC-1 and window==1.
  - Total open window = gesture_sec*TICKS_PER_SEC cycles, counted from the cycle after the first press.
- Completion beats timeout: a completing press in the timeout cycle finishes the gesture.
- gesture_sec is sampled only at window load. Changes while a window is open have no effect until the next load.
- gesture_pending = 1 exactly in ON_ARMING / OFF_ARMING.
- remain_sec = window in ARMING states, else 0.
- Window register is 6 bits; never underflows (left at 0 in IDLE states).
- Reset mid-window aborts immediately to OFF_IDLE with power_on=0. Power state is not retained.

Test Plan:
- Power-on gesture: reset; gesture_sec=5; left pulse at cycle 10; right pulse at cycle 200 → gesture_pending=1 from cycle 11; remain_sec 5→4 at cycle 110, 4→3 at cycle 210 is never reached; power_on=1 at cycle 201, gesture_pending=0.
- Timeout: gesture_sec=2; left at cycle 10; no right → remain_sec 2,1 then gesture_pending=0 and state OFF_IDLE at cycle 210; right at cycle 211 → no effect, power_on=0.
- Boundary completion: gesture_sec=1; left at cycle 10; right exactly at cycle 110 (timeout cycle) → power_on=1 at cycle 111.
- Power-off and restart: from ON_IDLE, gesture_sec=3; right at t0; right again at t0+250 → remain_sec reloads to 3; left at t0+500 → power_on=0.
- Degenerate inputs:
  - gesture_sec=0 with left press → stays OFF_IDLE.
  - Simultaneous left+right in ON_ARMING → no change.
  - Change gesture_sec 5→9 mid-window → remain_sec continues from the loaded 5.
- Async reset: assert rst_n low mid-window in OFF_ARMING (power_on=1) between clock edges → power_on=0, remain_sec=0, gesture_pending=0 immediately, without waiting for a clock edge.
